// File: rtl/req_ack_checker.sv
// req_ack_checker: passive multi-channel req/ack handshake monitor.
// Each channel runs an IDLE/WAIT FSM that times the ack against a
// MIN_LAT..MAX_LAT window and emits one-cycle error/pass pulses.
// Saturating pass/error totals and a sticky error flag summarise all channels.
module req_ack_checker #(
  parameter int NUM_CH  = 4,
  parameter int MIN_LAT = 1,
  parameter int MAX_LAT = 4,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clr_stats,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] ack,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] pass,
  output logic [NUM_CH-1:0] err_timeout,
  output logic [NUM_CH-1:0] err_early,
  output logic [NUM_CH-1:0] err_spurious,
  output logic [NUM_CH-1:0] err_overlap,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              sticky_err
);

  // Latency counter only ever holds 0..MAX_LAT.
  localparam int LAT_W = $clog2(MAX_LAT + 1);
  // Wide enough for the per-edge event count across all four error vectors.
  localparam int PC_W  = $clog2(4 * NUM_CH + 1);
  // Sum width for saturating adds: one bit above the wider operand.
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  localparam logic [LAT_W-1:0] LAT_MIN = LAT_W'(MIN_LAT);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);
  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t           state_q [NUM_CH];
  state_t           state_d [NUM_CH];
  logic [LAT_W-1:0] lat_q   [NUM_CH];
  logic [LAT_W-1:0] lat_d   [NUM_CH];

  logic [NUM_CH-1:0] pass_q, pass_d;
  logic [NUM_CH-1:0] timeout_q, timeout_d;
  logic [NUM_CH-1:0] early_q, early_d;
  logic [NUM_CH-1:0] spurious_q, spurious_d;
  logic [NUM_CH-1:0] overlap_q, overlap_d;

  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             sticky_err_q, sticky_err_d;

  logic [PC_W-1:0]  pass_inc;
  logic [PC_W-1:0]  err_inc;

  // Number of set bits in a channel vector.
  function automatic logic [PC_W-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  // Counter plus increment, clamped at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [PC_W-1:0]  inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cnt) + SUM_W'(inc);
    if (sum > SUM_W'(CNT_MAX)) begin
      return CNT_MAX;
    end
    return sum[CNT_W-1:0];
  endfunction

  // Channel state and latency registers; reset silently abandons open transactions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        lat_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        lat_q[i]   <= lat_d[i];
      end
    end
  end

  // Next state: a terminating event (ack or timeout) frees the channel, and a
  // same-edge req immediately opens the next transaction.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      lat_d[i]   = lat_q[i];
      if (!enable) begin
        state_d[i] = ST_IDLE;
        lat_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          ST_IDLE: begin
            if (req[i]) begin
              state_d[i] = ST_WAIT;
              lat_d[i]   = LAT_ONE;
            end
          end
          ST_WAIT: begin
            if (ack[i] || (lat_q[i] == LAT_MAX)) begin
              if (req[i]) begin
                state_d[i] = ST_WAIT;
                lat_d[i]   = LAT_ONE;
              end else begin
                state_d[i] = ST_IDLE;
                lat_d[i]   = '0;
              end
            end else begin
              lat_d[i] = lat_q[i] + LAT_ONE;
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            lat_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Event classification from the current state, latency and inputs.
  always_comb begin
    pass_d     = '0;
    timeout_d  = '0;
    early_d    = '0;
    spurious_d = '0;
    overlap_d  = '0;
    if (enable) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (state_q[i] == ST_IDLE) begin
          spurious_d[i] = ack[i];
        end else begin
          if (ack[i]) begin
            if (lat_q[i] >= LAT_MIN) begin
              pass_d[i] = 1'b1;
            end else begin
              early_d[i] = 1'b1;
            end
          end else if (lat_q[i] == LAT_MAX) begin
            timeout_d[i] = 1'b1;
          end else if (req[i]) begin
            overlap_d[i] = 1'b1;
          end
        end
      end
    end
  end

  // Statistics update; a clear on the same edge overrides any increment.
  always_comb begin
    pass_inc     = popcount(pass_d);
    err_inc      = popcount(timeout_d) + popcount(early_d)
                 + popcount(spurious_d) + popcount(overlap_d);
    pass_cnt_d   = sat_add(pass_cnt_q, pass_inc);
    err_cnt_d    = sat_add(err_cnt_q, err_inc);
    sticky_err_d = sticky_err_q | (err_inc != '0);
    if (clr_stats) begin
      pass_cnt_d   = '0;
      err_cnt_d    = '0;
      sticky_err_d = 1'b0;
    end
  end

  // Registered event pulses and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q       <= '0;
      timeout_q    <= '0;
      early_q      <= '0;
      spurious_q   <= '0;
      overlap_q    <= '0;
      pass_cnt_q   <= '0;
      err_cnt_q    <= '0;
      sticky_err_q <= 1'b0;
    end else begin
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      early_q      <= early_d;
      spurious_q   <= spurious_d;
      overlap_q    <= overlap_d;
      pass_cnt_q   <= pass_cnt_d;
      err_cnt_q    <= err_cnt_d;
      sticky_err_q <= sticky_err_d;
    end
  end

  // Busy is a direct decode of the state flop.
  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i] = (state_q[i] == ST_WAIT);
    end
  end

  assign pass         = pass_q;
  assign err_timeout  = timeout_q;
  assign err_early    = early_q;
  assign err_spurious = spurious_q;
  assign err_overlap  = overlap_q;
  assign pass_cnt     = pass_cnt_q;
  assign err_cnt      = err_cnt_q;
  assign sticky_err   = sticky_err_q;

endmodule

// File: tb/tb_req_ack_checker.sv
// tb_req_ack_checker: scoreboard bench for req_ack_checker.
// The driver advances a timestamp-based protocol model each edge and queues
// the expected outputs; an independent monitor pops and compares after each edge.
module tb_req_ack_checker;

  localparam int NUM_CH  = 4;
  localparam int MIN_LAT = 2;
  localparam int MAX_LAT = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              clr_stats;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] ack;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] pass;
  logic [NUM_CH-1:0] err_timeout;
  logic [NUM_CH-1:0] err_early;
  logic [NUM_CH-1:0] err_spurious;
  logic [NUM_CH-1:0] err_overlap;
  logic [CNT_W-1:0]  pass_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic              sticky_err;

  req_ack_checker #(
    .NUM_CH (NUM_CH),
    .MIN_LAT(MIN_LAT),
    .MAX_LAT(MAX_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .clr_stats   (clr_stats),
    .req         (req),
    .ack         (ack),
    .busy        (busy),
    .pass        (pass),
    .err_timeout (err_timeout),
    .err_early   (err_early),
    .err_spurious(err_spurious),
    .err_overlap (err_overlap),
    .pass_cnt    (pass_cnt),
    .err_cnt     (err_cnt),
    .sticky_err  (sticky_err)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] pass;
    logic [NUM_CH-1:0] tmo;
    logic [NUM_CH-1:0] early;
    logic [NUM_CH-1:0] spur;
    logic [NUM_CH-1:0] ovl;
    logic [CNT_W-1:0]  pcnt;
    logic [CNT_W-1:0]  ecnt;
    logic              sticky;
  } exp_t;

  exp_t exp_q[$];

  int tests_run    = 0;
  int tests_failed = 0;
  bit mon_on       = 1'b0;

  // Reference model: an open transaction is remembered by the edge number
  // at which its req was sampled; latency is the difference of edge numbers.
  bit m_open  [NUM_CH];
  int m_start [NUM_CH];
  int m_edge;
  int m_pcnt;
  int m_ecnt;
  bit m_sticky;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s at t=%0t: got 0x%0h, want 0x%0h", name, $time, act, expv);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_open[c]  = 1'b0;
      m_start[c] = 0;
    end
    m_edge   = 0;
    m_pcnt   = 0;
    m_ecnt   = 0;
    m_sticky = 1'b0;
  endtask

  task automatic modelStep(input logic en, input logic clr,
                           input logic [NUM_CH-1:0] r, input logic [NUM_CH-1:0] a,
                           output exp_t e);
    int  k;
    bit  done_txn;
    int  npass;
    int  nerr;
    e = '0;
    m_edge++;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!en) begin
        m_open[c] = 1'b0;
      end else if (!m_open[c]) begin
        if (a[c]) e.spur[c] = 1'b1;
        if (r[c]) begin
          m_open[c]  = 1'b1;
          m_start[c] = m_edge;
        end
      end else begin
        k        = m_edge - m_start[c];
        done_txn = 1'b0;
        if (a[c]) begin
          done_txn = 1'b1;
          if (k >= MIN_LAT) e.pass[c] = 1'b1;
          else              e.early[c] = 1'b1;
        end else if (k >= MAX_LAT) begin
          done_txn  = 1'b1;
          e.tmo[c]  = 1'b1;
        end
        if (done_txn) begin
          m_open[c] = r[c];
          if (r[c]) m_start[c] = m_edge;
        end else if (r[c]) begin
          e.ovl[c] = 1'b1;
        end
      end
      e.busy[c] = m_open[c];
    end
    npass = $countones(e.pass);
    nerr  = $countones(e.tmo) + $countones(e.early) + $countones(e.spur) + $countones(e.ovl);
    m_pcnt = (m_pcnt + npass > CNT_MAX) ? CNT_MAX : m_pcnt + npass;
    m_ecnt = (m_ecnt + nerr > CNT_MAX) ? CNT_MAX : m_ecnt + nerr;
    if (nerr > 0) m_sticky = 1'b1;
    if (clr) begin
      m_pcnt   = 0;
      m_ecnt   = 0;
      m_sticky = 1'b0;
    end
    e.pcnt   = CNT_W'(m_pcnt);
    e.ecnt   = CNT_W'(m_ecnt);
    e.sticky = m_sticky;
  endtask

  // Drive one edge's worth of inputs (called at a negedge), queue its expectation.
  task automatic applyStimulus(input logic en, input logic clr,
                               input logic [NUM_CH-1:0] r, input logic [NUM_CH-1:0] a);
    exp_t e;
    enable    = en;
    clr_stats = clr;
    req       = r;
    ack       = a;
    modelStep(en, clr, r, a, e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Assert reset asynchronously, confirm outputs clear before any clock edge,
  // hold it for n edges, then release at a negedge.
  task automatic applyReset(input int n);
    rst       = 1'b1;
    enable    = 1'b0;
    clr_stats = 1'b0;
    req       = '0;
    ack       = '0;
    #1;
    checkOutput("rst_async_clear",
                {busy, pass, err_timeout, err_early, err_spurious, err_overlap,
                 pass_cnt, err_cnt, sticky_err}, '0);
    modelReset();
    mon_on = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('0);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, '0, '0);
  endtask

  // Monitor: compare every output against the queued expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        if (exp_q.size() == 0) begin
          checkOutput("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("busy",         busy,         e.busy);
          checkOutput("pass",         pass,         e.pass);
          checkOutput("err_timeout",  err_timeout,  e.tmo);
          checkOutput("err_early",    err_early,    e.early);
          checkOutput("err_spurious", err_spurious, e.spur);
          checkOutput("err_overlap",  err_overlap,  e.ovl);
          checkOutput("pass_cnt",     pass_cnt,     e.pcnt);
          checkOutput("err_cnt",      err_cnt,      e.ecnt);
          checkOutput("sticky_err",   sticky_err,   e.sticky);
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run exceeded time limit, tests=%0d", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyReset(5);

    // In-window pass on ch0 (ack at latency 2).
    applyStimulus(1, 0, 4'b0001, 4'b0000);
    applyStimulus(1, 0, 4'b0000, 4'b0000);
    applyStimulus(1, 0, 4'b0000, 4'b0001);
    idle(1);

    // Timeout on ch1 after MAX_LAT edges.
    applyStimulus(1, 0, 4'b0010, 4'b0000);
    idle(5);

    // Early ack on ch0, then a spurious ack on ch3.
    applyStimulus(1, 0, 4'b0001, 4'b0000);
    applyStimulus(1, 0, 4'b0000, 4'b0001);
    applyStimulus(1, 0, 4'b0000, 4'b1000);
    idle(1);

    // Overlap on ch2, then pass; then back-to-back ack with new req.
    applyStimulus(1, 0, 4'b0100, 4'b0000);
    applyStimulus(1, 0, 4'b0100, 4'b0000);
    applyStimulus(1, 0, 4'b0000, 4'b0100);
    applyStimulus(1, 0, 4'b0100, 4'b0000);
    applyStimulus(1, 0, 4'b0000, 4'b0000);
    applyStimulus(1, 0, 4'b0100, 4'b0100);
    applyStimulus(1, 0, 4'b0000, 4'b0000);
    applyStimulus(1, 0, 4'b0000, 4'b0100);

    // All channels pass on the same edge.
    applyStimulus(1, 0, 4'b1111, 4'b0000);
    applyStimulus(1, 0, 4'b0000, 4'b0000);
    applyStimulus(1, 0, 4'b0000, 4'b1111);

    // Disable mid-WAIT: channel drops, no timeout afterwards.
    applyStimulus(1, 0, 4'b0010, 4'b0000);
    idle(1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 4'b0000, 4'b0000);
    idle(6);

    // Clear on an edge that also carries an error.
    applyStimulus(1, 1, 4'b0000, 4'b1000);
    idle(1);

    // Reset in the middle of a WAIT.
    applyStimulus(1, 0, 4'b0001, 4'b0000);
    idle(1);
    applyReset(2);
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 31) != 0), ($urandom_range(0, 63) == 0),
                    NUM_CH'($urandom & $urandom), NUM_CH'($urandom & $urandom));
    end

    // Pass counter saturation: 320 passes.
    applyStimulus(1, 1, 4'b0000, 4'b0000);
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1, 0, 4'b1111, 4'b0000);
      applyStimulus(1, 0, 4'b0000, 4'b0000);
      applyStimulus(1, 0, 4'b0000, 4'b1111);
    end
    checkOutput("pass_cnt_saturated", pass_cnt, CNT_MAX);

    // Error counter saturation: 280 spurious acks.
    for (int i = 0; i < 70; i++) applyStimulus(1, 0, 4'b0000, 4'b1111);
    checkOutput("err_cnt_saturated", err_cnt, CNT_MAX);
    applyStimulus(1, 1, 4'b0000, 4'b0000);
    idle(2);

    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
